// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destination writes behind D and
// decides per-operand stall/forward plus MDU structural stalls.
module hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int TW    = 2,
    parameter int AW    = 5,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_rs_use,
    input  logic          d_rt_use,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic          d_md,
    input  logic          d_start,
    input  logic          md_busy,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] a3;
        logic [TW-1:0] tnew;
        logic          start;
    } stage_t;

    typedef struct packed {
        logic          hit;
        logic [SW-1:0] k;
        logic [TW-1:0] tnew;
    } match_t;

    stage_t stage_q [1:DEPTH];
    stage_t stage_d [1:DEPTH];

    match_t rs_m;
    match_t rt_m;
    logic   rs_stall;
    logic   rt_stall;
    logic   md_stall;
    logic   live;
    logic   issue;

    // Scan oldest to youngest so the youngest matching stage is the last one kept.
    function automatic match_t find_match(input stage_t st [1:DEPTH],
                                          input logic [AW-1:0] src,
                                          input logic use_src);
        match_t m;
        m = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (use_src && (src != '0) && st[k].valid && (st[k].a3 == src)) begin
                m.hit  = 1'b1;
                m.k    = SW'(k);
                m.tnew = st[k].tnew;
            end
        end
        return m;
    endfunction

    assign rs_m     = find_match(stage_q, d_rs, d_rs_use);
    assign rt_m     = find_match(stage_q, d_rt, d_rt_use);
    assign rs_stall = rs_m.hit && (rs_m.tnew > d_rs_tuse);
    assign rt_stall = rt_m.hit && (rt_m.tnew > d_rt_tuse);
    assign md_stall = d_md && (md_busy || (stage_q[1].valid && stage_q[1].start));

    // Outputs are held at zero while in reset or while a flush kills the pipe.
    assign live       = reset && !flush;
    assign stall      = live && d_valid && (rs_stall || rt_stall || md_stall);
    assign fwd_rs_sel = (live && rs_m.hit && (rs_m.tnew == '0)) ? rs_m.k : '0;
    assign fwd_rt_sel = (live && rt_m.hit && (rt_m.tnew == '0)) ? rt_m.k : '0;
    assign issue      = d_valid && !stall && !flush;

    always_comb begin
        // NOTE: every stage_d element gets a value on every path, so no latch is inferred.
        stage_d[1] = '0;
        if (issue) begin
            stage_d[1] = {1'b1, d_a3, d_tnew, d_start};
        end
        for (int k = 2; k <= DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
            if (stage_q[k-1].tnew != '0) begin
                stage_d[k].tnew = stage_q[k-1].tnew - TW'(1);
            end
        end
        if (flush) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_d[k] = '0;
            end
        end
    end

    // NOTE: stage registers are reset because a stale valid entry would cause false stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every stage shifts from the pre-edge values.
            for (int k = 1; k <= DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: age-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;
    localparam int TW    = 2;
    localparam int AW    = 5;
    localparam int SW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          d_valid;
    logic [AW-1:0] d_a3;
    logic [TW-1:0] d_tnew;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic          d_rs_use;
    logic          d_rt_use;
    logic [TW-1:0] d_rs_tuse;
    logic [TW-1:0] d_rt_tuse;
    logic          d_md;
    logic          d_start;
    logic          md_busy;
    logic          flush;
    logic          stall;
    logic [SW-1:0] fwd_rs_sel;
    logic [SW-1:0] fwd_rt_sel;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard #(.DEPTH(DEPTH), .TW(TW), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_a3       (d_a3),
        .d_tnew     (d_tnew),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_use   (d_rs_use),
        .d_rt_use   (d_rt_use),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .d_md       (d_md),
        .d_start    (d_start),
        .md_busy    (md_busy),
        .flush      (flush),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a list of issued instructions, youngest first, each with its age.
    typedef struct {
        int a3;
        int tnew0;
        bit start;
        int age;
    } ent_t;

    ent_t mq[$];

    function automatic void op_eval(input int src, input bit use_s, input int tuse,
                                    output bit st, output int fwd);
        st  = 1'b0;
        fwd = 0;
        if (!use_s || src == 0) return;
        foreach (mq[i]) begin
            if (mq[i].a3 == src) begin
                int cur;
                cur = mq[i].tnew0 - (mq[i].age - 1);
                if (cur < 0) cur = 0;
                st  = (cur > tuse);
                fwd = (cur == 0) ? mq[i].age : 0;
                return;
            end
        end
    endfunction

    function automatic void model_eval(output bit st, output int frs, output int frt);
        bit rs_st, rt_st, md_st, live;
        int rsf, rtf;
        op_eval(int'(d_rs), d_rs_use, int'(d_rs_tuse), rs_st, rsf);
        op_eval(int'(d_rt), d_rt_use, int'(d_rt_tuse), rt_st, rtf);
        md_st = d_md && (md_busy || (mq.size() > 0 && mq[0].age == 1 && mq[0].start));
        live  = reset && !flush;
        st    = live && d_valid && (rs_st || rt_st || md_st);
        frs   = live ? rsf : 0;
        frt   = live ? rtf : 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else begin : advance
            bit   st;
            int   a, b;
            ent_t e;
            model_eval(st, a, b);
            foreach (mq[i]) mq[i].age++;
            while (mq.size() > 0 && mq[mq.size()-1].age > DEPTH) void'(mq.pop_back());
            if (flush) begin
                mq.delete();
            end else if (d_valid && !st) begin
                e.a3    = int'(d_a3);
                e.tnew0 = int'(d_tnew);
                e.start = d_start;
                e.age   = 1;
                mq.push_front(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit st;
        int frs, frt;
        model_eval(st, frs, frt);
        check("cyc_stall", {31'd0, stall}, {31'd0, st});
        check("cyc_fwd_rs", 32'(fwd_rs_sel), frs);
        check("cyc_fwd_rt", 32'(fwd_rt_sel), frt);
    end

    task automatic idle();
        d_valid = 0; d_a3 = '0; d_tnew = '0;
        d_rs = '0; d_rt = '0; d_rs_use = 0; d_rt_use = 0;
        d_rs_tuse = '0; d_rt_tuse = '0;
        d_md = 0; d_start = 0; md_busy = 0; flush = 0;
    endtask

    task automatic issue(input int a3, input int tnew);
        d_valid = 1;
        d_a3    = AW'(a3);
        d_tnew  = TW'(tnew);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH) next_cycle();
    endtask

    initial begin
        reset = 0;
        idle();
        d_valid = 1; d_md = 1; md_busy = 1;
        #3;
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_fwd_rs", 32'(fwd_rs_sel), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall2", {31'd0, stall}, 0);
        reset = 1;

        // Load-use: lw $8 (tnew 2) then add reading $8 at tuse 1.
        idle(); issue(8, 2);
        next_cycle();
        idle(); issue(10, 1); d_rs = 8; d_rs_use = 1; d_rs_tuse = 1;
        #1 check("lu_stall", {31'd0, stall}, 1);
        next_cycle();
        #1 check("lu_release", {31'd0, stall}, 0);
        check("lu_fwd_none", 32'(fwd_rs_sel), 0);
        next_cycle();
        #1 check("lu_fwd3", 32'(fwd_rs_sel), 3);
        check("lu_fwd3_stall", {31'd0, stall}, 0);
        drain();

        // ALU-branch on the rt path: addu $9 (tnew 1) then beq reading $9 at tuse 0.
        idle(); issue(9, 1);
        next_cycle();
        idle(); d_valid = 1; d_rt = 9; d_rt_use = 1; d_rt_tuse = 0;
        #1 check("br_stall", {31'd0, stall}, 1);
        next_cycle();
        #1 check("br_release", {31'd0, stall}, 0);
        check("br_fwd2", 32'(fwd_rt_sel), 2);
        drain();

        // Youngest wins: $5 in stage 1 (tnew 1) and stage 2 (tnew 0).
        idle(); issue(5, 1);
        next_cycle();
        idle(); issue(5, 1);
        next_cycle();
        idle(); d_valid = 1;
        d_rs = 5; d_rs_use = 1; d_rs_tuse = 0;
        d_rt = 5; d_rt_use = 1; d_rt_tuse = 3;
        #1 check("yw_stall", {31'd0, stall}, 1);
        check("yw_fwd_rs", 32'(fwd_rs_sel), 0);
        check("yw_fwd_rt", 32'(fwd_rt_sel), 0);
        next_cycle();
        #1 check("yw_after_stall", {31'd0, stall}, 0);
        check("yw_after_rs", 32'(fwd_rs_sel), 2);
        drain();

        // Register zero is never a producer.
        idle(); issue(0, 3);
        next_cycle();
        idle(); d_valid = 1; d_rs_use = 1; d_rt_use = 1;
        #1 check("r0_stall", {31'd0, stall}, 0);
        check("r0_fwd_rs", 32'(fwd_rs_sel), 0);
        check("r0_fwd_rt", 32'(fwd_rt_sel), 0);
        drain();

        // MDU: mult starts, mflo follows, then md_busy for 5 cycles.
        idle(); issue(0, 0); d_md = 1; d_start = 1;
        next_cycle();
        idle(); issue(12, 1); d_md = 1;
        #1 check("md_start", {31'd0, stall}, 1);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            md_busy = 1;
            #1 check("md_busy", {31'd0, stall}, 1);
        end
        next_cycle();
        md_busy = 0;
        #1 check("md_drop", {31'd0, stall}, 0);
        drain();

        // Flush with three valid entries.
        idle(); issue(3, 3);
        next_cycle();
        issue(4, 3);
        next_cycle();
        issue(6, 3);
        next_cycle();
        idle(); d_valid = 1; d_rs = 6; d_rs_use = 1;
        #1 check("fl_pre", {31'd0, stall}, 1);
        flush = 1;
        #1 check("fl_force", {31'd0, stall}, 0);
        next_cycle();
        flush = 0;
        #1 check("fl_post", {31'd0, stall}, 0);
        check("fl_post_fwd", 32'(fwd_rs_sel), 0);
        drain();

        // Reset pulsed mid-stall.
        idle(); issue(7, 3);
        next_cycle();
        idle(); d_valid = 1; d_rs = 7; d_rs_use = 1;
        #1 check("rs_pre", {31'd0, stall}, 1);
        reset = 0;
        #1 check("rs_async", {31'd0, stall}, 0);
        check("rs_async_fwd", 32'(fwd_rs_sel), 0);
        next_cycle();
        reset = 1;
        #1 check("rs_post", {31'd0, stall}, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
